// File: rtl/dsp_mac_sequencer_pkg.sv
// rtl/dsp_mac_sequencer_pkg.sv - shared types and OPMODE constants for the MAC sequencer
package dsp_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;
   localparam logic [7:0] OPM_HOLD  = 8'h08;

   typedef struct packed {
      logic valid;
      logic first;
   } tag_t;

   // First term loads P from M alone so a stale P never leaks into a new sum.
   function automatic logic [7:0] tag_opmode(input tag_t t);
      if (!t.valid) return OPM_HOLD;
      return t.first ? OPM_FIRST : OPM_ACC;
   endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - operand-pair stream between source and sequencer
interface dsp_mac_sequencer_if #(
   parameter int N_AB = 18
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [N_AB-1:0] a_in;
   logic signed [N_AB-1:0] b_in;

   modport master (output in_valid, output a_in, output b_in, input in_ready);
   modport slave  (input in_valid, input a_in, input b_in, output in_ready);
endinterface

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// rtl/dsp_mac_sequencer_tag_pipe.sv - term tag delay line matching the slice multiply latency
module dsp_tag_pipe
   import dsp_seq_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_flush,
   input  tag_t i_tag,
   output tag_t o_head,
   output logic o_any_valid
);

   tag_t r_stage [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_head = r_stage[DEPTH-1];

   always_comb begin
      o_any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | r_stage[i].valid;
   end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - drives a DSP48A1 slice as a signed dot-product MAC
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int N_AB    = 18,
   parameter int N_P     = 48,
   parameter int LEN_W   = 8,
   parameter int MUL_LAT = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic [LEN_W-1:0]       i_len,
   input  logic                   i_clr,
   dsp_mac_sequencer_if.slave     s_in,
   output logic signed [N_AB-1:0] o_a,
   output logic signed [N_AB-1:0] o_b,
   output logic                   o_ce,
   output logic [7:0]             o_opmode,
   output logic                   o_cep,
   output logic                   o_rstp,
   input  logic signed [N_P-1:0]  i_p,
   output logic signed [N_P-1:0]  o_result,
   output logic                   o_result_valid,
   output logic                   o_busy
);

   state_t                 r_state;
   state_t                 w_next;
   logic [LEN_W-1:0]       r_remaining;
   logic                   r_first;
   logic                   r_zero;
   logic signed [N_AB-1:0] r_a;
   logic signed [N_AB-1:0] r_b;
   logic [7:0]             r_opmode;
   logic                   r_cep;
   logic signed [N_P-1:0]  r_result;
   logic                   r_result_valid;

   logic w_ready;
   logic w_accept;
   logic w_start;
   logic w_any_valid;
   tag_t w_tag;
   tag_t w_head;

   assign w_ready  = (r_state == ST_RUN) && (r_remaining != '0) && !i_clr;
   assign w_accept = w_ready && s_in.in_valid;
   assign w_start  = (r_state == ST_IDLE) && i_start && !i_clr;
   assign w_tag    = '{valid: w_accept, first: w_accept && r_first};

   dsp_tag_pipe #(
      .DEPTH (MUL_LAT)
   ) u_tag_pipe (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_clr),
      .i_tag       (w_tag),
      .o_head      (w_head),
      .o_any_valid (w_any_valid)
   );

   always_comb begin
      w_next = r_state;
      if (i_clr) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (i_start) w_next = (i_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_accept && r_remaining == LEN_W'(1)) w_next = ST_DRAIN;
            ST_DRAIN: if (!w_any_valid) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_remaining    <= '0;
         r_first        <= 1'b0;
         r_zero         <= 1'b0;
         r_a            <= '0;
         r_b            <= '0;
         r_opmode       <= OPM_HOLD;
         r_cep          <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_result_valid <= (r_state == ST_DONE) && !i_clr;
         if ((r_state == ST_DONE) && !i_clr) r_result <= r_zero ? '0 : i_p;
         // The decode register is the last delay stage, so it is flushed with the pipe.
         if (i_clr) begin
            r_opmode <= OPM_HOLD;
            r_cep    <= 1'b0;
         end else begin
            r_opmode <= tag_opmode(w_head);
            r_cep    <= w_head.valid;
         end
         if (w_start) begin
            r_remaining <= i_len;
            r_first     <= 1'b1;
            r_zero      <= (i_len == '0);
         end
         if (w_accept) begin
            r_a         <= s_in.a_in;
            r_b         <= s_in.b_in;
            r_remaining <= r_remaining - LEN_W'(1);
            r_first     <= 1'b0;
         end
      end
   end

   assign s_in.in_ready  = w_ready;
   assign o_a            = r_a;
   assign o_b            = r_b;
   assign o_busy         = (r_state != ST_IDLE);
   assign o_ce           = o_busy;
   assign o_opmode       = r_opmode;
   assign o_cep          = r_cep;
   assign o_rstp         = i_clr || ((r_state == ST_IDLE) && i_start);
   assign o_result       = r_result;
   assign o_result_valid = r_result_valid;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - randomized self-checking bench with slice model and dot-product reference
module tb_dsp_mac_sequencer;

   localparam int N_AB    = 18;
   localparam int N_P     = 48;
   localparam int LEN_W   = 8;
   localparam int MUL_LAT = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic [LEN_W-1:0]       len = '0;
   logic                   clr = 1'b0;
   logic signed [N_AB-1:0] o_a, o_b;
   logic                   o_ce, o_cep, o_rstp, o_result_valid, o_busy;
   logic [7:0]             o_opmode;
   logic signed [N_P-1:0]  o_result;
   logic signed [N_P-1:0]  p_reg = '0;
   logic signed [N_P-1:0]  prod [MUL_LAT];

   dsp_mac_sequencer_if #(.N_AB(N_AB)) u_if ();

   dsp_mac_sequencer #(
      .N_AB(N_AB), .N_P(N_P), .LEN_W(LEN_W), .MUL_LAT(MUL_LAT)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_len          (len),
      .i_clr          (clr),
      .s_in           (u_if.slave),
      .o_a            (o_a),
      .o_b            (o_b),
      .o_ce           (o_ce),
      .o_opmode       (o_opmode),
      .o_cep          (o_cep),
      .o_rstp         (o_rstp),
      .i_p            (p_reg),
      .o_result       (o_result),
      .o_result_valid (o_result_valid),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   // Behavioural DSP48A1 slice: A/B/M stages gated by CE, P register with RSTP and CEP.
   always @(posedge clk) begin
      if (o_ce) begin
         prod[0] <= N_P'(longint'(o_a) * longint'(o_b));
         for (int i = 1; i < MUL_LAT; i++) prod[i] <= prod[i-1];
      end
      if (o_rstp) p_reg <= '0;
      else if (o_cep) begin
         case (o_opmode)
            8'h01:   p_reg <= prod[MUL_LAT-1];
            8'h09:   p_reg <= p_reg + prod[MUL_LAT-1];
            default: ;
         endcase
      end
   end

   int          cyc = 0;
   int          rv_cnt = 0;
   int          rv_cyc = 0;
   logic [47:0] rv_val = '0;
   int          cep_cnt = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   int          op_a [16];
   int          op_b [16];
   int          gap  [16];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_result_valid) begin
         rv_cnt = rv_cnt + 1;
         rv_cyc = cyc;
         rv_val = o_result;
      end
      if (o_cep) cep_cnt = cep_cnt + 1;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
      else n_pass++;
   endtask

   function automatic int rnd18();
      logic signed [17:0] v;
      v = 18'($urandom & 32'h3ffff);
      return int'(v);
   endfunction

   // Runs one dot product of n terms from op_a/op_b with gap[i] bubbles before term i.
   task automatic run_dot(input int n, input string tag, input bit hold_start);
      longint      sum;
      logic [47:0] exp48;
      int          l_last;
      int          guard;
      sum = 0;
      for (int i = 0; i < n; i++) sum += longint'(op_a[i]) * longint'(op_b[i]);
      exp48   = sum[47:0];
      rv_cnt  = 0;
      cep_cnt = 0;
      start   = 1'b1;
      len     = LEN_W'(n);
      #1 chk({tag, "_rstp"}, 64'(o_rstp), 64'd1);
      @(negedge clk);
      l_last = cyc;
      start  = hold_start;
      for (int i = 0; i < n; i++) begin
         u_if.in_valid = 1'b0;
         repeat (gap[i]) @(negedge clk);
         u_if.in_valid = 1'b1;
         u_if.a_in     = N_AB'(op_a[i]);
         u_if.b_in     = N_AB'(op_b[i]);
         guard = 0;
         while (!u_if.in_ready && guard < 8) begin
            @(negedge clk);
            guard++;
         end
         if (i == 0 || !u_if.in_ready) chk({tag, "_ready"}, 64'(u_if.in_ready), 64'd1);
         @(negedge clk);
         l_last = cyc;
      end
      u_if.in_valid = 1'b0;
      for (int k = 0; k < MUL_LAT + 8; k++) begin
         if (hold_start) start = o_busy;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_rv_count"}, 64'(rv_cnt), 64'd1);
      chk({tag, "_rv_time"}, 64'(rv_cyc), 64'(l_last + ((n == 0) ? 1 : MUL_LAT + 2)));
      chk({tag, "_result"}, {16'h0, rv_val}, {16'h0, exp48});
      chk({tag, "_cep_cycles"}, 64'(cep_cnt), 64'(n));
      chk({tag, "_idle"}, 64'(o_busy), 64'd0);
   endtask

   task automatic set_ops3();
      op_a[0] = 3;  op_a[1] = -2; op_a[2] = 5;
      op_b[0] = 4;  op_b[1] = 7;  op_b[2] = -1;
      for (int i = 0; i < 16; i++) gap[i] = 0;
   endtask

   initial begin
      u_if.in_valid = 1'b0;
      u_if.a_in     = '0;
      u_if.b_in     = '0;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(u_if.in_ready), 64'd0);
      chk("reset_opmode", 64'(o_opmode), 64'h08);
      chk("reset_busy_ce_cep", {61'd0, o_busy, o_ce, o_cep}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outs", {o_a, o_b, o_result_valid, o_rstp, o_busy}, 64'd0);
      chk("idle_result", 64'(o_result), 64'd0);

      set_ops3();
      run_dot(3, "b2b_first", 1'b0);
      run_dot(3, "b2b_second", 1'b0);
      gap[2] = 2;
      run_dot(3, "bubble", 1'b0);

      for (int i = 0; i < 16; i++) gap[i] = 0;
      op_a[0] = -131072; op_b[0] = -131072;
      op_a[1] = -131072; op_b[1] = -131072;
      run_dot(2, "max_neg", 1'b0);
      run_dot(0, "len_zero", 1'b0);

      // Abort one cycle after the second accept of a four-term run.
      rv_cnt = 0;
      start = 1'b1; len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         u_if.in_valid = 1'b1; u_if.a_in = 18'(i + 1); u_if.b_in = 18'(i + 2);
         @(negedge clk);
      end
      u_if.in_valid = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      #1 chk("clr_rstp", 64'(o_rstp), 64'd1);
      chk("clr_ready", 64'(u_if.in_ready), 64'd0);
      @(negedge clk);
      clr = 1'b0;
      chk("clr_idle", 64'(o_busy), 64'd0);
      chk("clr_opmode", 64'(o_opmode), 64'h08);
      repeat (10) @(negedge clk);
      chk("clr_no_result", 64'(rv_cnt), 64'd0);
      op_a[0] = 6; op_b[0] = 7;
      run_dot(1, "after_clr", 1'b0);

      // Asynchronous reset while draining.
      set_ops3();
      rv_cnt = 0;
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         u_if.in_valid = 1'b1; u_if.a_in = 18'(op_a[i]); u_if.b_in = 18'(op_b[i]);
         @(negedge clk);
      end
      u_if.in_valid = 1'b0;
      chk("drain_busy", 64'(o_busy), 64'd1);
      #1 rst_n = 1'b0;
      #1 chk("async_rst_ctl", {58'd0, o_busy, o_ce, o_cep, o_result_valid, u_if.in_ready, o_rstp}, 64'd0);
      chk("async_rst_opmode", 64'(o_opmode), 64'h08);
      chk("async_rst_data", {o_a, o_b}, 64'd0);
      chk("async_rst_result", 64'(o_result), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_no_result", 64'(rv_cnt), 64'd0);
      op_a[0] = -1; op_b[0] = 1;
      run_dot(1, "after_rst", 1'b0);

      set_ops3();
      run_dot(3, "start_held", 1'b1);

      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            op_a[i] = rnd18();
            op_b[i] = rnd18();
            gap[i]  = $urandom_range(0, 2);
         end
         run_dot(n, $sformatf("rand%0d", r), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

endmodule
